bufram_burst: RTL and testbench

//  Single-clock, parametrised successor of the DDR-wrapper buffer RAM. Port A: random-access

---
 rtl/bufram_burst_pkg.sv | 18 +
 rtl/bufram_burst_dpram.sv | 46 ++++
 rtl/bufram_burst.sv | 160 ++++++++++++++++
 tb/tb_bufram_burst.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/bufram_burst_pkg.sv
// Shared definitions for the burst buffer RAM: default geometry, derived widths
// and the port-B sequencer state encoding.
package bufram_burst_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_ADDR_WIDTH = 3;
    localparam int DEF_BURST_LEN  = 4;

    localparam int BE_WIDTH = DEF_DATA_WIDTH / 8;
    localparam int BEAT_W   = $clog2(DEF_BURST_LEN);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_STREAM = 2'd2
    } state_t;

endpackage

// File: rtl/bufram_burst_dpram.sv
// Inferred simple dual-port RAM: one byte-enabled write port, two registered read
// ports. Read registers are reset so the outputs start at zero; the array is not.
module bufram_burst_dpram
    import bufram_burst_pkg::*;
#(
    parameter int DW = DEF_DATA_WIDTH,
    parameter int AW = DEF_ADDR_WIDTH
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [DW/8-1:0] we,
    input  logic [AW-1:0]   a_addr,
    input  logic [DW-1:0]   wd,
    output logic [DW-1:0]   a_q,
    input  logic            b_en,
    input  logic [AW-1:0]   b_addr,
    output logic [DW-1:0]   b_q
);

    localparam int NB    = DW / 8;
    localparam int DEPTH = 2 ** AW;

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        for (int i = 0; i < NB; i++) begin
            if (we[i]) begin
                mem[a_addr][8*i +: 8] <= wd[8*i +: 8];
            end
        end
    end

    // Non-blocking reads see the pre-write contents (read-before-write).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q <= '0;
            b_q <= '0;
        end else begin
            a_q <= mem[a_addr];
            if (b_en) begin
                b_q <= mem[b_addr];
            end
        end
    end

endmodule

// File: rtl/bufram_burst.sv
// Buffer RAM with a random-access port A and a valid/ready burst-read port B,
// per-entry valid bits and write-to-read forwarding into the port-B output stage.
module bufram_burst
    import bufram_burst_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int BURST_LEN  = DEF_BURST_LEN
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ADDR_WIDTH-1:0]   a_addr,
    input  logic [DATA_WIDTH/8-1:0] a_we,
    input  logic [DATA_WIDTH-1:0]   a_di,
    output logic [DATA_WIDTH-1:0]   a_do,
    input  logic                    flush,
    input  logic                    b_start,
    input  logic [ADDR_WIDTH-1:0]   b_addr,
    input  logic                    b_wrap,
    output logic                    b_busy,
    output logic                    b_valid,
    input  logic                    b_ready,
    output logic [DATA_WIDTH-1:0]   b_data,
    output logic                    b_hit,
    output logic                    b_last
);

    // Handshake: a beat transfers on any cycle where b_valid && b_ready. While b_valid
    // is high and b_ready low, b_data/b_hit/b_last hold; b_valid never drops without
    // an accept (except on reset).

    localparam int NB    = DATA_WIDTH / 8;
    localparam int CW    = $clog2(BURST_LEN);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] WRAP_MASK = ADDR_WIDTH'(BURST_LEN - 1);
    localparam logic [CW-1:0]         LAST_BEAT = CW'(BURST_LEN - 1);

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   base_q;
    logic                    wrap_q;
    logic [CW-1:0]           beat_q, load_beat;
    logic                    valid_q, hit_q;
    logic [NB-1:0]           fwd_mask_q;
    logic [DATA_WIDTH-1:0]   fwd_data_q, rb_q;
    logic [DEPTH-1:0]        vbits_q, vbits_d, wr_onehot;
    logic                    accept, last_beat, start_ok, load_en;
    logic [ADDR_WIDTH-1:0]   lin_addr, rd_addr;

    bufram_burst_dpram #(
        .DW (DATA_WIDTH),
        .AW (ADDR_WIDTH)
    ) u_ram (
        .clk    (clk),
        .rst    (rst),
        .we     (a_we),
        .a_addr (a_addr),
        .wd     (a_di),
        .a_q    (a_do),
        .b_en   (load_en),
        .b_addr (rd_addr),
        .b_q    (rb_q)
    );

    assign accept    = valid_q && b_ready;
    assign last_beat = (beat_q == LAST_BEAT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        start_ok = 1'b0;
        load_en  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (b_start) begin
                    start_ok = 1'b1;
                    state_d  = ST_LOAD;
                end
            end
            ST_LOAD: begin
                load_en = 1'b1;
                state_d = ST_STREAM;
            end
            ST_STREAM: begin
                if (accept) begin
                    if (!last_beat) begin
                        load_en = 1'b1;
                    end else if (b_start) begin
                        start_ok = 1'b1;
                        state_d  = ST_LOAD;
                    end else begin
                        state_d  = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Address of the beat being loaded this cycle; wrap keeps the upper bits fixed.
    always_comb begin
        load_beat = (state_q == ST_LOAD) ? '0 : beat_q + CW'(1);
        lin_addr  = base_q + ADDR_WIDTH'(load_beat);
        rd_addr   = wrap_q ? ((base_q & ~WRAP_MASK) | (lin_addr & WRAP_MASK)) : lin_addr;
    end

    always_comb begin
        wr_onehot = '0;
        for (int i = 0; i < DEPTH; i++) begin
            wr_onehot[i] = (a_we != '0) && (a_addr == ADDR_WIDTH'(i));
        end
        vbits_d = (flush ? '0 : vbits_q) | wr_onehot;
    end

    always_comb begin
        b_data = rb_q;
        for (int i = 0; i < NB; i++) begin
            if (fwd_mask_q[i]) b_data[8*i +: 8] = fwd_data_q[8*i +: 8];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            base_q     <= '0;
            wrap_q     <= 1'b0;
            beat_q     <= '0;
            valid_q    <= 1'b0;
            hit_q      <= 1'b0;
            fwd_mask_q <= '0;
            fwd_data_q <= '0;
            vbits_q    <= '0;
        end else begin
            vbits_q <= vbits_d;
            if (start_ok) begin
                base_q <= b_addr;
                wrap_q <= b_wrap;
            end
            // The counter wraps naturally to zero on the last accept.
            if (start_ok)    beat_q <= '0;
            else if (accept) beat_q <= beat_q + CW'(1);
            if (load_en)     valid_q <= 1'b1;
            else if (accept) valid_q <= 1'b0;
            // A stalled beat keeps its captured forward mask, so later writes cannot alter it.
            if (load_en) begin
                hit_q      <= vbits_d[rd_addr];
                fwd_mask_q <= (a_addr == rd_addr) ? a_we : '0;
                fwd_data_q <= a_di;
            end
        end
    end

    assign b_busy  = (state_q != ST_IDLE);
    assign b_valid = valid_q;
    assign b_hit   = hit_q;
    assign b_last  = valid_q && last_beat;

endmodule

// File: tb/tb_bufram_burst.sv
// Directed bench for bufram_burst (32-bit words, 8 entries, 4-beat bursts).
module tb_bufram_burst;
    import bufram_burst_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    logic [2:0]        a_addr;
    logic [BE_WIDTH-1:0] a_we;
    logic [31:0]       a_di;
    logic [31:0]       a_do;
    logic              flush;
    logic              b_start;
    logic [2:0]        b_addr;
    logic              b_wrap;
    logic              b_busy;
    logic              b_valid;
    logic              b_ready;
    logic [31:0]       b_data;
    logic              b_hit;
    logic              b_last;

    int checks   = 0;
    int failures = 0;
    logic [31:0] exp_mem [8];

    bufram_burst #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (3),
        .BURST_LEN  (4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .a_addr  (a_addr),
        .a_we    (a_we),
        .a_di    (a_di),
        .a_do    (a_do),
        .flush   (flush),
        .b_start (b_start),
        .b_addr  (b_addr),
        .b_wrap  (b_wrap),
        .b_busy  (b_busy),
        .b_valid (b_valid),
        .b_ready (b_ready),
        .b_data  (b_data),
        .b_hit   (b_hit),
        .b_last  (b_last)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic write_word(input logic [2:0] addr, input logic [3:0] we, input logic [31:0] data);
        a_addr = addr;
        a_we   = we;
        a_di   = data;
        for (int i = 0; i < 4; i++) begin
            if (we[i]) exp_mem[addr][8*i +: 8] = data[8*i +: 8];
        end
        tick();
        a_we = '0;
    endtask

    task automatic start_burst(input logic [2:0] addr, input logic wrap);
        b_start = 1'b1;
        b_addr  = addr;
        b_wrap  = wrap;
        tick();
        b_start = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        for (int i = 0; i < 8 && b_valid !== 1'b1; i++) tick();
        chk(tag, {31'd0, b_valid}, 32'd1);
    endtask

    // addrs packs beat addresses {a3,a2,a1,a0}; hits is the per-beat hit pattern.
    task automatic expect_burst(input string tag, input logic [11:0] addrs, input logic [3:0] hits);
        b_ready = 1'b1;
        wait_valid({tag, "_start"});
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("%s_data%0d", tag, k), b_data, exp_mem[addrs[3*k +: 3]]);
            chk($sformatf("%s_hit%0d", tag, k), {31'd0, b_hit}, {31'd0, hits[k]});
            chk($sformatf("%s_last%0d", tag, k), {31'd0, b_last}, {31'd0, k == 3});
            tick();
        end
        chk({tag, "_end_busy"}, {31'd0, b_busy}, 32'd0);
        chk({tag, "_end_valid"}, {31'd0, b_valid}, 32'd0);
    endtask

    initial begin
        rst = 1'b1; a_addr = '0; a_we = '0; a_di = '0; flush = 1'b0;
        b_start = 1'b0; b_addr = '0; b_wrap = 1'b0; b_ready = 1'b1;
        for (int i = 0; i < 8; i++) exp_mem[i] = 'x;
        tick(); tick();
        chk("rst_a_do", a_do, 32'd0);
        chk("rst_busy", {31'd0, b_busy}, 32'd0);
        chk("rst_valid", {31'd0, b_valid}, 32'd0);
        chk("rst_data", b_data, 32'd0);
        chk("rst_hit", {31'd0, b_hit}, 32'd0);
        chk("rst_last", {31'd0, b_last}, 32'd0);
        rst = 1'b0;
        tick();

        // 1: fill and linear burst from 2
        for (int i = 0; i < 8; i++) write_word(3'(i), 4'hF, {8{4'(i + 1)}});
        start_burst(3'd2, 1'b0);
        expect_burst("lin2", {3'd5, 3'd4, 3'd3, 3'd2}, 4'b1111);
        chk("lin2_beat0_const", exp_mem[2], 32'h33333333);

        // 2: wrap and linear from 6
        start_burst(3'd6, 1'b1);
        expect_burst("wrap6", {3'd5, 3'd4, 3'd7, 3'd6}, 4'b1111);
        start_burst(3'd6, 1'b0);
        expect_burst("lin6", {3'd1, 3'd0, 3'd7, 3'd6}, 4'b1111);

        // 3: stall on beat 1
        start_burst(3'd2, 1'b0);
        wait_valid("stall_start");
        chk("stall_b0", b_data, 32'h33333333);
        tick();
        b_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_hold_data", b_data, 32'h44444444);
            chk("stall_hold_valid", {31'd0, b_valid}, 32'd1);
            chk("stall_hold_last", {31'd0, b_last}, 32'd0);
        end
        b_ready = 1'b1;
        chk("stall_b1", b_data, 32'h44444444);
        tick();
        chk("stall_b2", b_data, 32'h55555555);
        tick();
        chk("stall_b3", b_data, 32'h66666666);
        chk("stall_b3_last", {31'd0, b_last}, 32'd1);
        tick();
        chk("stall_end_busy", {31'd0, b_busy}, 32'd0);

        // 4: forwarding into the beat-1 load (addr 3)
        start_burst(3'd2, 1'b0);
        wait_valid("fwd_start");
        chk("fwd_b0", b_data, 32'h33333333);
        write_word(3'd3, 4'b0011, 32'hAAAABBBB);
        chk("fwd_b1", b_data, 32'h4444BBBB);
        chk("fwd_b1_hit", {31'd0, b_hit}, 32'd1);
        tick(); tick(); tick();
        chk("fwd_end_busy", {31'd0, b_busy}, 32'd0);
        a_addr = 3'd3;
        tick();
        chk("fwd_a_do", a_do, 32'h4444BBBB);

        // 5: flush clears hits; a write during flush wins
        flush = 1'b1;
        tick();
        flush = 1'b0;
        start_burst(3'd0, 1'b0);
        expect_burst("flush", {3'd3, 3'd2, 3'd1, 3'd0}, 4'b0000);
        flush = 1'b1;
        write_word(3'd1, 4'hF, 32'h12345678);
        flush = 1'b0;
        start_burst(3'd0, 1'b0);
        expect_burst("flushwr", {3'd3, 3'd2, 3'd1, 3'd0}, 4'b0010);

        // 6: reset mid-burst, then normal burst, then back-to-back
        for (int i = 0; i < 8; i++) write_word(3'(i), 4'hF, exp_mem[i]);
        start_burst(3'd0, 1'b0);
        wait_valid("rstmid_start");
        tick(); tick();
        rst = 1'b1;
        tick();
        chk("rstmid_valid", {31'd0, b_valid}, 32'd0);
        chk("rstmid_busy", {31'd0, b_busy}, 32'd0);
        rst = 1'b0;
        tick();
        chk("rstmid_idle", {31'd0, b_busy}, 32'd0);
        start_burst(3'd0, 1'b0);
        expect_burst("postrst", {3'd3, 3'd2, 3'd1, 3'd0}, 4'b0000);

        start_burst(3'd4, 1'b0);
        wait_valid("b2b_start");
        for (int k = 0; k < 3; k++) begin
            chk("b2b_first", b_data, exp_mem[4 + k]);
            tick();
        end
        chk("b2b_first_last", {31'd0, b_last}, 32'd1);
        b_start = 1'b1; b_addr = 3'd1; b_wrap = 1'b1;
        tick();
        b_start = 1'b0;
        chk("b2b_gap_busy", {31'd0, b_busy}, 32'd1);
        tick();
        chk("b2b_second_valid", {31'd0, b_valid}, 32'd1);
        chk("b2b_second_b0", b_data, 32'h12345678);
        tick();
        // Start while busy without last accept must be ignored.
        b_ready = 1'b0; b_start = 1'b1; b_addr = 3'd6; b_wrap = 1'b0;
        tick();
        b_start = 1'b0; b_ready = 1'b1;
        chk("b2b_second_b1", b_data, 32'h33333333);
        tick();
        chk("b2b_second_b2", b_data, 32'h4444BBBB);
        tick();
        chk("b2b_second_b3", b_data, 32'h11111111);
        chk("b2b_second_last", {31'd0, b_last}, 32'd1);
        tick();
        chk("b2b_end_busy", {31'd0, b_busy}, 32'd0);
        tick();
        chk("ignored_start_idle", {31'd0, b_busy}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
